ascon_aead_sequencer: RTL

//  Control FSM sequencing one Ascon-128 AEAD encryption over the shared permutation core.

---
 rtl/ascon_aead_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ascon_aead_sequencer.sv
// Control FSM for one Ascon-128 AEAD encryption over the shared permutation core.
// Define ASCON_SEQ_STATS_EN to enable the saturating perm_count_o statistics counter.
module ascon_aead_sequencer #(
  parameter int unsigned ROUNDS_A     = 12,
  parameter int unsigned ROUNDS_B     = 6,
  parameter int unsigned PERM_TIMEOUT = 31
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        blk_valid_i,
  input  logic        blk_is_ad_i,
  input  logic        blk_last_i,
  output logic        blk_ready_o,
  output logic        ld_init_o,
  output logic        perm_start_o,
  output logic [3:0]  perm_rounds_o,
  input  logic        perm_done_i,
  output logic        xor_key_init_o,
  output logic        absorb_o,
  output logic        dom_sep_o,
  output logic        xor_key_final_o,
  output logic        tag_valid_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [15:0] perm_count_o
);

  localparam logic [3:0] RoundsA   = ROUNDS_A[3:0];
  localparam logic [3:0] RoundsB   = ROUNDS_B[3:0];
  localparam logic [4:0] TimeoutM1 = 5'(PERM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, INIT_LD, INIT_P, INIT_K, AD_WAIT, AD_P, DSEP,
    MSG_WAIT, MSG_P, FIN_K, FIN_P, TAG, ERR
  } seqState_e;

  seqState_e   state_q;
  logic        ldInit_q, permStart_q, xorKeyInit_q, absorb_q;
  logic        domSep_q, xorKeyFinal_q, tagValid_q, adLast_q;
  logic [3:0]  permRounds_q;
  logic [4:0]  wdCnt_q;
  logic        permDoneSeen, wdExpired;

  // A done pulse coinciding with the start strobe cannot belong to this permutation.
  assign permDoneSeen = perm_done_i && !permStart_q;
  assign wdExpired    = (wdCnt_q == TimeoutM1);

  always_comb begin
    blk_ready_o = 1'b0;
    if (!abort_i) begin
      if (state_q == AD_WAIT)  blk_ready_o = blk_is_ad_i;
      if (state_q == MSG_WAIT) blk_ready_o = !blk_is_ad_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      ldInit_q      <= 1'b0;
      permStart_q   <= 1'b0;
      permRounds_q  <= 4'd0;
      xorKeyInit_q  <= 1'b0;
      absorb_q      <= 1'b0;
      domSep_q      <= 1'b0;
      xorKeyFinal_q <= 1'b0;
      tagValid_q    <= 1'b0;
      adLast_q      <= 1'b0;
      wdCnt_q       <= 5'd0;
    end else begin
      ldInit_q      <= 1'b0;
      permStart_q   <= 1'b0;
      permRounds_q  <= 4'd0;
      xorKeyInit_q  <= 1'b0;
      absorb_q      <= 1'b0;
      domSep_q      <= 1'b0;
      xorKeyFinal_q <= 1'b0;
      tagValid_q    <= 1'b0;
      if (abort_i) begin
        state_q <= IDLE;
        wdCnt_q <= 5'd0;
      end else begin
        unique case (state_q)
          IDLE: if (start_i) begin
            state_q  <= INIT_LD;
            ldInit_q <= 1'b1;
          end
          INIT_LD: begin
            state_q      <= INIT_P;
            permStart_q  <= 1'b1;
            permRounds_q <= RoundsA;
            wdCnt_q      <= 5'd0;
          end
          INIT_P, AD_P, MSG_P, FIN_P: begin
            if (permDoneSeen) begin
              wdCnt_q <= 5'd0;
              unique case (state_q)
                INIT_P: begin
                  state_q      <= INIT_K;
                  xorKeyInit_q <= 1'b1;
                end
                AD_P: if (adLast_q) begin
                  state_q  <= DSEP;
                  domSep_q <= 1'b1;
                end else begin
                  state_q <= AD_WAIT;
                end
                MSG_P: state_q <= MSG_WAIT;
                default: begin
                  state_q    <= TAG;
                  tagValid_q <= 1'b1;
                end
              endcase
            end else if (wdExpired) begin
              state_q <= ERR;
              wdCnt_q <= 5'd0;
            end else begin
              wdCnt_q <= wdCnt_q + 5'd1;
            end
          end
          INIT_K: state_q <= AD_WAIT;
          AD_WAIT: if (blk_valid_i) begin
            if (blk_is_ad_i) begin
              state_q      <= AD_P;
              absorb_q     <= 1'b1;
              permStart_q  <= 1'b1;
              permRounds_q <= RoundsB;
              wdCnt_q      <= 5'd0;
              adLast_q     <= blk_last_i;
            end else begin
              // A message block here means the AD phase is over (or empty).
              state_q  <= DSEP;
              domSep_q <= 1'b1;
            end
          end
          DSEP: state_q <= MSG_WAIT;
          MSG_WAIT: if (blk_valid_i) begin
            if (blk_is_ad_i) begin
              state_q <= ERR;
            end else if (blk_last_i) begin
              // The last message block goes straight to finalization, unpermuted.
              state_q       <= FIN_K;
              absorb_q      <= 1'b1;
              xorKeyFinal_q <= 1'b1;
            end else begin
              state_q      <= MSG_P;
              absorb_q     <= 1'b1;
              permStart_q  <= 1'b1;
              permRounds_q <= RoundsB;
              wdCnt_q      <= 5'd0;
            end
          end
          FIN_K: begin
            state_q      <= FIN_P;
            permStart_q  <= 1'b1;
            permRounds_q <= RoundsA;
            wdCnt_q      <= 5'd0;
          end
          TAG: state_q <= IDLE;
          ERR: state_q <= ERR;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ld_init_o       = ldInit_q;
  assign perm_start_o    = permStart_q;
  assign perm_rounds_o   = permRounds_q;
  assign xor_key_init_o  = xorKeyInit_q;
  assign absorb_o        = absorb_q;
  assign dom_sep_o       = domSep_q;
  assign xor_key_final_o = xorKeyFinal_q;
  assign tag_valid_o     = tagValid_q;
  assign busy_o          = (state_q != IDLE);
  assign err_o           = (state_q == ERR);

`ifdef ASCON_SEQ_STATS_EN
  logic [15:0] permCount_q, permCount_d;

  // Counts issued permutations; survives abort, cleared only by reset.
  always_comb begin
    permCount_d = permCount_q;
    if (permStart_q && (permCount_q != 16'hFFFF)) permCount_d = permCount_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) permCount_q <= 16'h0000;
    else       permCount_q <= permCount_d;
  end

  assign perm_count_o = permCount_q;
`else
  assign perm_count_o = 16'h0000;
`endif

endmodule
